// File: rtl/slave_poll_master.sv
// slave_poll_master
// Polls up to NUM_SLAVES capture chips over the shared 8-bit address/data
// bus. The 64-bit captured word of each slave is read one byte at a time and
// offered on a valid/ready stream with its slave ID and the timestamp of the
// snapshot that found it. Once every snapshotted slave has been read, 8'hFF
// is broadcast for two cycles so the slaves re-arm.
//
// Ports
//   clkin        sole clock, all registers on posedge
//   rst_n        asynchronous active-low reset
//   enwipe_in    per-slave enwipeout, 0 = slave holds an unread capture
//   cs_in        per-slave cs, 1 = slave is serving byte reads
//   data_in      shared data bus from the slaves
//   address      shared address bus: {id,2'b00,byte}, 8'hFF release, 8'hFE idle
//   frame_valid  frame_* outputs hold a complete word
//   frame_ready  downstream accepts the frame when valid & ready at posedge
//   frame_data   byte k of the word in bits [8k+7:8k]
//   frame_id     slave ID of the frame
//   frame_ts     cycle counter value latched at the snapshot
//   drop_cnt     saturating count of captures discarded by the release
//   proto_err    sticky: a slave had cs low at a byte sample
//   busy         poller is not idle
module slave_poll_master #(
  parameter int unsigned NUM_SLAVES  = 8,
  parameter int unsigned SAMPLE_WAIT = 1,
  parameter int unsigned TS_WIDTH    = 32
) (
  input  logic                  clkin,
  input  logic                  rst_n,
  input  logic [NUM_SLAVES-1:0] enwipe_in,
  input  logic [NUM_SLAVES-1:0] cs_in,
  input  logic [7:0]            data_in,
  output logic [7:0]            address,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic [63:0]           frame_data,
  output logic [2:0]            frame_id,
  output logic [TS_WIDTH-1:0]   frame_ts,
  output logic [15:0]           drop_cnt,
  output logic                  proto_err,
  output logic                  busy
);

  localparam int unsigned WW = (SAMPLE_WAIT < 2) ? 1 : $clog2(SAMPLE_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE, SNAP, SELECT, ADDR, EMIT, RELEASE, GUARD
  } state_t;

  state_t                state;
  logic [TS_WIDTH-1:0]   ts_cnt;
  logic [TS_WIDTH-1:0]   snap_ts;
  logic [NUM_SLAVES-1:0] pending;
  logic [NUM_SLAVES-1:0] snapshot;
  logic [2:0]            cur_id;
  logic [2:0]            byte_idx;
  logic [WW-1:0]         wait_cnt;
  logic                  rel_cnt;

  logic [7:0]            cs_ext;
  logic [2:0]            low_id;
  logic                  pend_any;
  logic [NUM_SLAVES-1:0] dropped;
  logic [NUM_SLAVES-1:0] cur_mask;
  logic [3:0]            drop_pop;
  logic [16:0]           drop_sum;
  logic [15:0]           drop_next;
  logic                  last_wait;

  always_comb begin
    cs_ext = '0;
    cs_ext[NUM_SLAVES-1:0] = cs_in;
    low_id   = '0;
    pend_any = 1'b0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (pending[i] && !pend_any) begin
        low_id   = 3'(i);
        pend_any = 1'b1;
      end
    end
    // Captures that appeared after the snapshot are wiped by the release.
    dropped  = ~enwipe_in & ~snapshot;
    drop_pop = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      drop_pop = drop_pop + 4'(dropped[i]);
    end
    drop_sum  = {1'b0, drop_cnt} + 17'(drop_pop);
    drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    cur_mask  = NUM_SLAVES'(1) << cur_id;
    last_wait = (wait_cnt == WW'(SAMPLE_WAIT));
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ts_cnt      <= '0;
      snap_ts     <= '0;
      pending     <= '0;
      snapshot    <= '0;
      cur_id      <= '0;
      byte_idx    <= '0;
      wait_cnt    <= '0;
      rel_cnt     <= 1'b0;
      address     <= 8'hFE;
      frame_valid <= 1'b0;
      frame_data  <= '0;
      frame_id    <= '0;
      frame_ts    <= '0;
      drop_cnt    <= '0;
      proto_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (~enwipe_in != '0) begin
            state <= SNAP;
            busy  <= 1'b1;
          end
        end
        SNAP: begin
          pending  <= ~enwipe_in;
          snapshot <= ~enwipe_in;
          snap_ts  <= ts_cnt;
          state    <= SELECT;
        end
        SELECT: begin
          if (pend_any) begin
            cur_id   <= low_id;
            byte_idx <= '0;
            wait_cnt <= '0;
            address  <= {low_id, 5'b00000};
            state    <= ADDR;
          end else begin
            // Drops are counted on the entering edge, while enwipe_in still
            // shows every capture that the release is about to wipe.
            drop_cnt <= drop_next;
            address  <= 8'hFF;
            rel_cnt  <= 1'b0;
            state    <= RELEASE;
          end
        end
        ADDR: begin
          if (last_wait) begin
            frame_data[{byte_idx, 3'b000} +: 8] <= data_in;
            if (!cs_ext[cur_id]) proto_err <= 1'b1;
            wait_cnt <= '0;
            if (byte_idx == 3'd7) begin
              frame_valid <= 1'b1;
              frame_id    <= cur_id;
              frame_ts    <= snap_ts;
              state       <= EMIT;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              address  <= {cur_id, 2'b00, byte_idx + 3'd1};
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        EMIT: begin
          if (frame_ready) begin
            frame_valid <= 1'b0;
            pending     <= pending & ~cur_mask;
            state       <= SELECT;
          end
        end
        RELEASE: begin
          if (rel_cnt) begin
            address <= 8'hFE;
            state   <= GUARD;
          end else begin
            rel_cnt <= 1'b1;
          end
        end
        GUARD: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_poll_master.sv
module tb_slave_poll_master;

  logic        clkin = 1'b0;
  logic        rst_n;
  logic [7:0]  enwipe_in, cs_in, data_in, address;
  logic        frame_valid, frame_ready;
  logic [63:0] frame_data;
  logic [2:0]  frame_id;
  logic [31:0] frame_ts;
  logic [15:0] drop_cnt;
  logic        proto_err, busy;

  slave_poll_master #(.NUM_SLAVES(8), .SAMPLE_WAIT(1), .TS_WIDTH(32)) dut (
    .clkin(clkin), .rst_n(rst_n), .enwipe_in(enwipe_in), .cs_in(cs_in),
    .data_in(data_in), .address(address), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .frame_data(frame_data), .frame_id(frame_id),
    .frame_ts(frame_ts), .drop_cnt(drop_cnt), .proto_err(proto_err), .busy(busy)
  );

  always #5 clkin = ~clkin;

  // Slave chip model: a captured word per slave, released by address 8'hFF.
  logic [7:0]  captured = '0;
  logic [7:0]  cs_low = '0;
  logic [63:0] words [8];

  always_comb begin
    enwipe_in = ~captured;
    cs_in     = captured & ~cs_low;
    data_in   = words[address[7:5]][{address[2:0], 3'b000} +: 8];
  end

  // Cycle count since reset release: the expected timestamp base.
  logic [31:0] cyc;
  always @(posedge clkin or negedge rst_n)
    if (!rst_n) cyc <= '0; else cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  id;
    logic [63:0] data;
    logic [31:0] ts;
  } frame_t;

  frame_t     exp_q[$];
  logic [7:0] trace_q[$];
  logic [7:0] exp_trace[$];
  logic [7:0] last_addr;
  int         ff_cycles, nframes, exp_drop, ready_mode, inj_id;
  bit         seen_rel, rnd_inj, inj_pending, exp_proto;
  logic [7:0] inj_addr;
  int         errors = 0;
  int         checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // One cycle of bench activity, performed at the negedge.
  task automatic step();
    int id;
    frame_t f;
    @(negedge clkin);
    if (address == 8'hFF) begin
      captured  = '0;
      ff_cycles++;
      seen_rel  = 1'b1;
    end
    if (address !== last_addr) begin
      trace_q.push_back(address);
      last_addr = address;
    end
    if (busy && address != 8'hFE && address != 8'hFF) begin
      if (inj_pending && address == inj_addr) begin
        captured[inj_id] = 1'b1;
        exp_drop++;
        inj_pending = 1'b0;
      end
      if (rnd_inj && $urandom_range(0, 15) == 0) begin
        id = $urandom_range(0, 7);
        if (!captured[id]) begin
          words[id] = {$urandom, $urandom};
          captured[id] = 1'b1;
          exp_drop++;
        end
      end
    end
    case (ready_mode)
      0:       frame_ready = 1'b1;
      1:       frame_ready = ($urandom_range(0, 2) != 0);
      default: frame_ready = 1'b0;
    endcase
    if (frame_valid && frame_ready) begin
      nframes++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got id %0d data %h, required none", frame_id, frame_data);
      end else begin
        f = exp_q.pop_front();
        check("frame_id", 64'(frame_id), 64'(f.id));
        check("frame_data", frame_data, f.data);
        check("frame_ts", 64'(frame_ts), 64'(f.ts));
      end
    end
  endtask

  // Called at a negedge with the poller idle: slaves in mask capture now.
  task automatic start_round(input logic [7:0] mask, input logic [63:0] w0);
    bit first = 1'b1;
    frame_t f;
    exp_trace.delete();
    trace_q.delete();
    last_addr = 8'hFE;
    ff_cycles = 0;
    seen_rel  = 1'b0;
    nframes   = 0;
    for (int k = 0; k < 8; k++) begin
      if (mask[k]) begin
        words[k] = first ? w0 : (~w0 ^ {8{8'(k)}});
        first = 1'b0;
        f.id = 3'(k);
        f.data = words[k];
        f.ts = cyc + 1;
        exp_q.push_back(f);
        for (int b = 0; b < 8; b++) exp_trace.push_back({3'(k), 2'b00, 3'(b)});
      end
    end
    exp_trace.push_back(8'hFF);
    exp_trace.push_back(8'hFE);
    captured = captured | mask;
  endtask

  task automatic finish_round(input string tag);
    int n = 0;
    int bad = -1;
    do begin
      step();
      n++;
    end while (!(exp_q.size() == 0 && seen_rel && address == 8'hFE && !busy) && n < 3000);
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d frames still expected after %0d cycles, required 0", tag, exp_q.size(), n);
      exp_q.delete();
    end
    if (trace_q.size() != exp_trace.size()) bad = 0;
    else
      for (int i = 0; i < trace_q.size(); i++)
        if (bad < 0 && trace_q[i] !== exp_trace[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s_addr_trace: %0d addresses, first diff at %0d got %h required %h (of %0d)", tag,
               trace_q.size(), bad, (bad < trace_q.size()) ? trace_q[bad] : 8'hxx,
               (bad < exp_trace.size()) ? exp_trace[bad] : 8'hxx, exp_trace.size());
    end
    check({tag, "_ff_cycles"}, 64'(ff_cycles), 64'd2);
    check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
    check({tag, "_proto_err"}, 64'(proto_err), 64'(exp_proto));
  endtask

  typedef struct {
    logic [7:0]  mask;
    logic [63:0] w0;
    bit          inj;
    int          inj_id;
    logic [7:0]  inj_addr;
    int          exp_frames;
    int          exp_drop;
  } vec_t;

  initial begin
    vec_t tbl[5];
    logic [63:0] d;
    logic [2:0]  fid;
    logic [31:0] fts;
    logic [7:0]  a;
    bit ok;
    int n;

    tbl[0] = '{8'h04, 64'h0123_4567_89AB_CDEF, 1'b0, 0, 8'h00, 1, 0};
    tbl[1] = '{8'h22, 64'h1122_3344_5566_7788, 1'b0, 0, 8'h00, 2, 0};
    tbl[2] = '{8'h01, 64'h0F1E_2D3C_4B5A_6978, 1'b1, 3, 8'h03, 1, 1};
    tbl[3] = '{8'h80, 64'hFF00_0000_0000_0000, 1'b0, 0, 8'h00, 1, 1};
    tbl[4] = '{8'hFF, 64'h5A5A_C3C3_0110_7EE7, 1'b0, 0, 8'h00, 8, 1};

    for (int k = 0; k < 8; k++) words[k] = '0;
    frame_ready = 1'b0;
    ready_mode = 0; rnd_inj = 1'b0; inj_pending = 1'b0; exp_drop = 0; exp_proto = 1'b0;
    last_addr = 8'hFE;

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clkin);
    check("rst_address", 64'(address), 64'hFE);
    check("rst_frame_valid", 64'(frame_valid), 64'd0);
    check("rst_frame_data", frame_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      inj_pending = tbl[i].inj;
      inj_id      = tbl[i].inj_id;
      inj_addr    = tbl[i].inj_addr;
      start_round(tbl[i].mask, tbl[i].w0);
      finish_round($sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_frames", i), 64'(nframes), 64'(tbl[i].exp_frames));
      check($sformatf("tbl%0d_drop", i), 64'(drop_cnt), 64'(tbl[i].exp_drop));
    end

    // Downstream stalls 20 cycles on a complete frame.
    start_round(8'h10, 64'hA5A5_0F0F_3C3C_9696);
    ready_mode = 2;
    n = 0;
    while (!frame_valid && n < 200) begin step(); n++; end
    check("stall_reach_valid", 64'(frame_valid), 64'd1);
    d = frame_data; fid = frame_id; fts = frame_ts; a = address;
    ok = 1'b1;
    repeat (20) begin
      step();
      if (frame_valid !== 1'b1 || frame_data !== d || frame_id !== fid ||
          frame_ts !== fts || address !== a || busy !== 1'b1) ok = 1'b0;
    end
    check("stall_stable", 64'(ok), 64'd1);
    ready_mode = 0;
    finish_round("stall");

    // Random captures, random backpressure, random late captures.
    ready_mode = 1;
    rnd_inj = 1'b1;
    for (int r = 0; r < 25; r++) begin
      start_round(8'($urandom_range(1, 255)), {$urandom, $urandom});
      finish_round($sformatf("rnd%0d", r));
    end
    rnd_inj = 1'b0;
    ready_mode = 0;

    // Slave with cs low while its bytes are sampled.
    cs_low = 8'h08;
    exp_proto = 1'b1;
    start_round(8'h08, 64'hDEAD_BEEF_CAFE_F00D);
    finish_round("proto");
    cs_low = '0;

    // Reset while byte 4 of slave 6 is on the bus.
    start_round(8'h40, 64'h0011_2233_4455_6677);
    n = 0;
    while (address !== 8'hC4 && n < 200) begin step(); n++; end
    check("mid_reach_byte4", 64'(address), 64'hC4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_address", 64'(address), 64'hFE);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_proto_err", 64'(proto_err), 64'd0);
    check("mid_rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("mid_rst_frame", {frame_data[60:0], frame_valid, frame_id[1:0]} | 64'(frame_ts), 64'd0);
    exp_q.delete();
    exp_drop = 0;
    exp_proto = 1'b0;
    @(negedge clkin);
    rst_n = 1'b1;
    start_round(8'h40, 64'h0011_2233_4455_6677);
    finish_round("reread");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
